// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-access stage.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  // Lane mask for an access of 1<<size bytes starting at byte offset.
  function automatic logic [7:0] byte_enables(input mem_size_t size, input logic [2:0] offset);
    logic [7:0] mask;
    case (size)
      SZ_BYTE:  mask = 8'h01;
      SZ_HALF:  mask = 8'h03;
      SZ_WORD:  mask = 8'h0F;
      default:  mask = 8'hFF;
    endcase
    return mask << offset;
  endfunction

  function automatic logic is_aligned(input mem_size_t size, input logic [2:0] offset);
    logic [2:0] low_bits;
    case (size)
      SZ_BYTE:  low_bits = 3'b000;
      SZ_HALF:  low_bits = 3'b001;
      SZ_WORD:  low_bits = 3'b011;
      default:  low_bits = 3'b111;
    endcase
    return (offset & low_bits) == 3'b000;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Extracts the addressed lanes from an aligned doubleword and sign/zero-extends them.
module load_align
  import mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [2:0]      offset_i,
  input  mem_size_t       size_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0] shifted;

  assign shifted = data_i >> {offset_i, 3'b000};

  always_comb begin
    result_o = shifted;
    case (size_i)
      SZ_BYTE:  result_o = {{(XLEN-8){~unsigned_i & shifted[7]}},   shifted[7:0]};
      SZ_HALF:  result_o = {{(XLEN-16){~unsigned_i & shifted[15]}}, shifted[15:0]};
      SZ_WORD:  result_o = {{(XLEN-32){~unsigned_i & shifted[31]}}, shifted[31:0]};
      default:  result_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: ALU pass-through, aligned loads/stores over a
// valid/ready data port, single write-back register that also feeds forwarding.
module mem_stage
  import mem_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RW   = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_result,
  input  logic [RW-1:0]   ex_rd,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic            ex_load,
  input  logic            ex_store,
  input  logic [1:0]      ex_size,
  input  logic            ex_unsigned,
  output logic            ex_stall,
  output logic [RW-1:0]   fwd_rd,
  output logic [XLEN-1:0] fwd_val,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_req_addr,
  output logic            dmem_req_we,
  output logic [XLEN-1:0] dmem_req_wdata,
  output logic [7:0]      dmem_req_be,
  input  logic            dmem_resp_valid,
  input  logic [XLEN-1:0] dmem_resp_data,
  output logic            wb_valid,
  output logic [RW-1:0]   wb_rd,
  output logic [XLEN-1:0] wb_val,
  output logic            misalign
);

  mem_state_t      state_q, state_d;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] sdata_q;
  logic [RW-1:0]   rd_q;
  logic            store_q;
  mem_size_t       size_q;
  logic            uns_q;
  logic            wb_valid_q;
  logic [RW-1:0]   wb_rd_q;
  logic [XLEN-1:0] wb_val_q;
  logic            misalign_q;
  logic [XLEN-1:0] load_data;

  logic accept;
  logic ex_is_load;
  logic ex_is_store;
  logic ex_is_mem;
  logic ex_aligned;

  assign accept      = ex_valid && !ex_stall;
  // Load and store both set is an illegal encoding and falls through as an ALU op.
  assign ex_is_load  = ex_load & ~ex_store;
  assign ex_is_store = ex_store & ~ex_load;
  assign ex_is_mem   = ex_is_load | ex_is_store;
  assign ex_aligned  = is_aligned(mem_size_t'(ex_size), ex_result[2:0]);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && ex_is_mem && ex_aligned) state_d = REQ;
      REQ:  if (dmem_req_ready) state_d = store_q ? IDLE : WAIT;
      WAIT: if (dmem_resp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ex_stall       = (state_q != IDLE);
    dmem_req_valid = (state_q == REQ);
    dmem_req_addr  = '0;
    dmem_req_we    = 1'b0;
    dmem_req_wdata = '0;
    dmem_req_be    = '0;
    if (state_q == REQ) begin
      dmem_req_addr  = {addr_q[XLEN-1:3], 3'b000};
      dmem_req_we    = store_q;
      dmem_req_wdata = sdata_q << {addr_q[2:0], 3'b000};
      dmem_req_be    = byte_enables(size_q, addr_q[2:0]);
    end
    fwd_rd   = (wb_valid_q && (wb_rd_q != '0)) ? wb_rd_q : '0;
    fwd_val  = wb_val_q;
    wb_valid = wb_valid_q;
    wb_rd    = wb_rd_q;
    wb_val   = wb_val_q;
    misalign = misalign_q;
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .data_i     (dmem_resp_data),
    .offset_i   (addr_q[2:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .result_o   (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      sdata_q    <= '0;
      rd_q       <= '0;
      store_q    <= 1'b0;
      size_q     <= SZ_BYTE;
      uns_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_val_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      if (accept) begin
        addr_q  <= ex_result;
        sdata_q <= ex_store_data;
        rd_q    <= ex_rd;
        store_q <= ex_is_store;
        size_q  <= mem_size_t'(ex_size);
        uns_q   <= ex_unsigned;
        if (!ex_is_mem) begin
          wb_valid_q <= 1'b1;
          wb_rd_q    <= ex_rd;
          wb_val_q   <= ex_result;
        end else if (!ex_aligned) begin
          misalign_q <= 1'b1;
        end
      end
      if (state_q == WAIT && dmem_resp_valid) begin
        wb_valid_q <= 1'b1;
        wb_rd_q    <= rd_q;
        wb_val_q   <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected write-backs are queued at issue and
// popped by a negedge monitor; request fields and stall timing checked inline.
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [63:0] ex_result;
  logic [5:0]  ex_rd;
  logic [63:0] ex_store_data;
  logic        ex_load, ex_store;
  logic [1:0]  ex_size;
  logic        ex_unsigned;
  logic        ex_stall;
  logic [5:0]  fwd_rd;
  logic [63:0] fwd_val;
  logic        dmem_req_valid, dmem_req_ready;
  logic [63:0] dmem_req_addr;
  logic        dmem_req_we;
  logic [63:0] dmem_req_wdata;
  logic [7:0]  dmem_req_be;
  logic        dmem_resp_valid;
  logic [63:0] dmem_resp_data;
  logic        wb_valid;
  logic [5:0]  wb_rd;
  logic [63:0] wb_val;
  logic        misalign;

  typedef struct {
    logic [5:0]  rd;
    logic [63:0] val;
  } wb_exp_t;

  wb_exp_t wb_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(64), .RW(6)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_rd(ex_rd),
    .ex_store_data(ex_store_data), .ex_load(ex_load), .ex_store(ex_store),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_stall(ex_stall),
    .fwd_rd(fwd_rd), .fwd_val(fwd_val),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_addr(dmem_req_addr), .dmem_req_we(dmem_req_we),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_be(dmem_req_be),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_val(wb_val), .misalign(misalign)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (!reset && wb_valid) begin
      if (wb_q.size() == 0) begin
        chk("wb_unexpected", wb_valid, 1'b0);
      end else begin
        wb_exp_t e;
        e = wb_q.pop_front();
        $display("wb rd=%0d val=0x%0h (exp rd=%0d val=0x%0h)", wb_rd, wb_val, e.rd, e.val);
        chk("wb_rd", wb_rd, e.rd);
        chk("wb_val", wb_val, e.val);
        chk("fwd_rd", fwd_rd, e.rd);
        chk("fwd_val", fwd_val, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                        input logic [63:0] res, input logic [5:0] rd, input logic [63:0] sd);
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_size = sz; ex_unsigned = uns;
    ex_result = res; ex_rd = rd; ex_store_data = sd;
  endtask

  task automatic set_idle();
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_size = 2'd0; ex_unsigned = 1'b0;
    ex_result = '0; ex_rd = '0; ex_store_data = '0;
  endtask

  // Holds off ready for dly cycles, checking the request stays stable, then handshakes.
  task automatic req_phase(input int dly, input logic [63:0] a, input bit we,
                           input logic [63:0] wd, input logic [7:0] be, output int stall_cnt);
    stall_cnt = 0;
    for (int i = 0; i <= dly; i++) begin
      @(negedge clk);
      chk("req_valid", dmem_req_valid, 1'b1);
      chk("req_addr", dmem_req_addr, a);
      chk("req_we", dmem_req_we, we);
      chk("req_wdata", dmem_req_wdata, wd);
      chk("req_be", dmem_req_be, be);
      if (ex_stall) stall_cnt++;
      if (i == dly) begin
        dmem_req_ready = 1'b1;
        $display("req addr=0x%0h we=%0d wdata=0x%0h be=0x%0h", dmem_req_addr, dmem_req_we,
                 dmem_req_wdata, dmem_req_be);
      end
      step();
      dmem_req_ready = 1'b0;
    end
  endtask

  task automatic do_load(input logic [63:0] addr, input logic [1:0] sz, input bit uns,
                         input logic [5:0] rd, input logic [63:0] mem, input int rdy_dly,
                         input int resp_dly, input logic [7:0] be, input logic [63:0] exp);
    int sc;
    wb_q.push_back('{rd: rd, val: exp});
    set_op(1'b1, 1'b0, sz, uns, addr, rd, 64'h0);
    step();
    set_idle();
    req_phase(rdy_dly, {addr[63:3], 3'b000}, 1'b0, 64'h0, be, sc);
    for (int i = 0; i < resp_dly; i++) begin
      @(negedge clk);
      chk("load_wait_stall", ex_stall, 1'b1);
      step();
    end
    @(negedge clk);
    chk("load_wait_stall", ex_stall, 1'b1);
    dmem_resp_valid = 1'b1;
    dmem_resp_data  = mem;
    step();
    dmem_resp_valid = 1'b0;
    dmem_resp_data  = '0;
    @(negedge clk);
    chk("load_done_stall", ex_stall, 1'b0);
    chk("load_wb_valid", wb_valid, 1'b1);
  endtask

  initial begin
    int sc;
    reset = 1'b1;
    dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b0;
    dmem_resp_data = '0;
    set_idle();
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_stall", ex_stall, 1'b0);
    chk("rst_req_valid", dmem_req_valid, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_val", wb_val, 64'h0);
    chk("rst_fwd_rd", fwd_rd, 6'd0);
    chk("rst_misalign", misalign, 1'b0);

    // Back-to-back ALU ops
    wb_q.push_back('{rd: 6'd5, val: 64'h11});
    wb_q.push_back('{rd: 6'd6, val: 64'h22});
    set_op(1'b0, 1'b0, 2'd3, 1'b0, 64'h11, 6'd5, 64'h0);
    step();
    set_op(1'b0, 1'b0, 2'd3, 1'b0, 64'h22, 6'd6, 64'h0);
    @(negedge clk);
    chk("alu1_wb_valid", wb_valid, 1'b1);
    chk("alu1_stall", ex_stall, 1'b0);
    step();
    set_idle();
    @(negedge clk);
    chk("alu2_wb_valid", wb_valid, 1'b1);
    chk("alu2_fwd_rd", fwd_rd, 6'd6);
    chk("alu2_stall", ex_stall, 1'b0);
    step();
    @(negedge clk);
    chk("alu_idle_wb_valid", wb_valid, 1'b0);
    chk("alu_idle_fwd_rd", fwd_rd, 6'd0);
    chk("alu_hold_wb_val", wb_val, 64'h22);

    // Loads across sizes, offsets and extension modes
    do_load(64'h1003, 2'd0, 1'b0, 6'd7, 64'h0000_0000_8000_0000, 0, 1, 8'h08, 64'hFFFF_FFFF_FFFF_FF80);
    do_load(64'h1003, 2'd0, 1'b1, 6'd8, 64'h0000_0000_8000_0000, 1, 0, 8'h08, 64'h80);
    do_load(64'h1006, 2'd1, 1'b0, 6'd9, 64'h8123_0000_0000_0000, 2, 0, 8'hC0, 64'hFFFF_FFFF_FFFF_8123);
    do_load(64'h1004, 2'd2, 1'b1, 6'd10, 64'hDEAD_BEEF_0000_0000, 0, 0, 8'hF0, 64'hDEAD_BEEF);
    do_load(64'h1004, 2'd2, 1'b0, 6'd11, 64'hDEAD_BEEF_0000_0000, 0, 2, 8'hF0, 64'hFFFF_FFFF_DEAD_BEEF);
    do_load(64'h1008, 2'd3, 1'b0, 6'd12, 64'h0123_4567_89AB_CDEF, 1, 1, 8'hFF, 64'h0123_4567_89AB_CDEF);

    // Store half with ready held off three cycles
    set_op(1'b0, 1'b1, 2'd1, 1'b0, 64'h1006, 6'd13, 64'hBEEF);
    step();
    set_idle();
    req_phase(3, 64'h1000, 1'b1, 64'hBEEF_0000_0000_0000, 8'hC0, sc);
    chk("store_stall_cycles", sc, 4);
    @(negedge clk);
    chk("store_done_stall", ex_stall, 1'b0);
    chk("store_no_wb", wb_valid, 1'b0);

    // Misaligned word load is dropped
    set_op(1'b1, 1'b0, 2'd2, 1'b0, 64'h1002, 6'd14, 64'h0);
    step();
    set_idle();
    @(negedge clk);
    chk("mis_pulse", misalign, 1'b1);
    chk("mis_req_valid", dmem_req_valid, 1'b0);
    chk("mis_stall", ex_stall, 1'b0);
    step();
    @(negedge clk);
    chk("mis_pulse_end", misalign, 1'b0);
    chk("mis_req_valid2", dmem_req_valid, 1'b0);

    // Stray response while idle is ignored
    dmem_resp_valid = 1'b1;
    dmem_resp_data = 64'hFFFF;
    step();
    dmem_resp_valid = 1'b0;
    @(negedge clk);
    chk("stray_resp_stall", ex_stall, 1'b0);

    // Reset during WAIT, late response ignored
    set_op(1'b1, 1'b0, 2'd3, 1'b0, 64'h2000, 6'd15, 64'h0);
    step();
    set_idle();
    req_phase(0, 64'h2000, 1'b0, 64'h0, 8'hFF, sc);
    @(negedge clk);
    chk("wait_stall", ex_stall, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst2_stall", ex_stall, 1'b0);
    chk("rst2_req_valid", dmem_req_valid, 1'b0);
    chk("rst2_req_addr", dmem_req_addr, 64'h0);
    chk("rst2_req_be", dmem_req_be, 8'h0);
    chk("rst2_wb_valid", wb_valid, 1'b0);
    chk("rst2_wb_rd", wb_rd, 6'd0);
    chk("rst2_fwd_val", fwd_val, 64'h0);
    chk("rst2_misalign", misalign, 1'b0);
    step();
    dmem_resp_valid = 1'b1;
    dmem_resp_data = 64'hAAAA_5555_AAAA_5555;
    step();
    dmem_resp_valid = 1'b0;
    @(negedge clk);
    chk("late_resp_stall", ex_stall, 1'b0);
    chk("late_resp_wb", wb_valid, 1'b0);

    wb_q.push_back('{rd: 6'd16, val: 64'h33});
    set_op(1'b0, 1'b0, 2'd0, 1'b0, 64'h33, 6'd16, 64'h0);
    step();
    set_idle();
    @(negedge clk);
    chk("post_rst_alu_wb", wb_valid, 1'b1);

    // ALU op targeting x0: write-back but no forwarding
    wb_q.push_back('{rd: 6'd0, val: 64'h44});
    set_op(1'b0, 1'b0, 2'd0, 1'b0, 64'h44, 6'd0, 64'h0);
    step();
    set_idle();
    @(negedge clk);
    chk("x0_wb_valid", wb_valid, 1'b1);
    chk("x0_fwd_rd", fwd_rd, 6'd0);

    // Illegal load+store encoding behaves as ALU op
    wb_q.push_back('{rd: 6'd17, val: 64'h1001});
    set_op(1'b1, 1'b1, 2'd3, 1'b0, 64'h1001, 6'd17, 64'h0);
    step();
    set_idle();
    @(negedge clk);
    chk("illegal_wb_valid", wb_valid, 1'b1);
    chk("illegal_req_valid", dmem_req_valid, 1'b0);

    repeat (2) step();
    chk("sb_empty", wb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
